// File: rtl/scr1_imem_prefetch_q.sv
// scr1_imem_prefetch_q: in-order instruction prefetch queue between fetch logic and the IMEM bridge
//   clk, rst_n (async, active-low)
//   new_pc_req/new_pc  : redirect, flushes the queue and discards in-flight responses
//   fetch_stop         : blocks new requests, in-flight ones still complete
//   imem_*             : core-side memory request/response channel
//   instr_*            : queue head toward decode, instr_rdy pops it
//   SCR1_IMEM_PF_ERR_HALT_EN : when defined, an error response stops fetching until the next redirect
package scr1_imem_pf_pkg;
  localparam int SCR1_AHB_WIDTH = 32;
  typedef enum logic {SCR1_MEM_CMD_RD = 1'b0, SCR1_MEM_CMD_WR = 1'b1} type_scr1_mem_cmd_e;
  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_imem_prefetch_q
  import scr1_imem_pf_pkg::*;
#(
  parameter int PQ_DEPTH = 4,
  parameter int PQ_OUTST_MAX = 2,
  parameter logic [SCR1_AHB_WIDTH-1:0] PQ_RST_VECTOR = 32'h0000_0200
) (
  input  logic                      rst_n,
  input  logic                      clk,
  input  logic                      new_pc_req,
  input  logic [SCR1_AHB_WIDTH-1:0] new_pc,
  input  logic                      fetch_stop,
  input  logic                      imem_req_ack,
  output logic                      imem_req,
  output type_scr1_mem_cmd_e        imem_cmd,
  output logic [SCR1_AHB_WIDTH-1:0] imem_addr,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_rdata,
  input  type_scr1_mem_resp_e       imem_resp,
  output logic                      instr_vld,
  input  logic                      instr_rdy,
  output logic [SCR1_AHB_WIDTH-1:0] instr,
  output logic [SCR1_AHB_WIDTH-1:0] instr_pc,
  output logic                      instr_err
);
  localparam int W = SCR1_AHB_WIDTH;
  localparam int PW = (PQ_DEPTH > 1) ? $clog2(PQ_DEPTH) : 1;
  localparam int CW = $clog2(PQ_DEPTH + 1);
  localparam int LAST = PQ_DEPTH - 1;
  localparam logic [PW-1:0] LAST_P = LAST[PW-1:0];
  localparam logic [CW:0] DEPTH_C = PQ_DEPTH[CW:0];
  localparam logic [CW-1:0] OUTST_C = PQ_OUTST_MAX[CW-1:0];
  localparam logic [W-1:0] ALIGN_M = ~W'(3);
  localparam logic [W-1:0] RST_PC = PQ_RST_VECTOR & ALIGN_M;
  logic [W-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, new_pc_al;
  logic [CW-1:0] q_cnt_q, q_cnt_d, outst_cnt_q, outst_cnt_d, disc_cnt_q, disc_cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [W-1:0] q_data_q [PQ_DEPTH];
  logic [W-1:0] q_data_d [PQ_DEPTH];
  logic [W-1:0] q_pc_q [PQ_DEPTH];
  logic [W-1:0] q_pc_d [PQ_DEPTH];
  logic q_err_q [PQ_DEPTH];
  logic q_err_d [PQ_DEPTH];
  logic halt, accept, resp_rdy, resp_er, drop, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction
  assign new_pc_al = new_pc & ALIGN_M;
  // gated by rst_n so the request drops the moment reset asserts
  assign imem_req = rst_n & ~fetch_stop & ~new_pc_req & ~halt & (outst_cnt_q < OUTST_C)
                  & (({1'b0, q_cnt_q} + {1'b0, outst_cnt_q}) < DEPTH_C);
  assign imem_cmd = SCR1_MEM_CMD_RD;
  assign imem_addr = fetch_pc_q;
  assign accept = imem_req & imem_req_ack;
  assign resp_er = imem_resp == SCR1_MEM_RESP_RDY_ER;
  assign resp_rdy = (imem_resp == SCR1_MEM_RESP_RDY_OK) | resp_er;
  assign drop = disc_cnt_q != '0;
  // a response arriving with a redirect belongs to the old stream
  assign push = resp_rdy & ~drop & ~new_pc_req;
  assign pop = instr_vld & instr_rdy & ~new_pc_req;
  assign instr_vld = q_cnt_q != '0;
  assign instr = q_data_q[rd_ptr_q];
  assign instr_pc = q_pc_q[rd_ptr_q];
  assign instr_err = instr_vld & q_err_q[rd_ptr_q];
`ifdef SCR1_IMEM_PF_ERR_HALT_EN
  logic halt_q, halt_d;
  assign halt_d = new_pc_req ? 1'b0 : (push & resp_er) ? 1'b1 : halt_q;
  assign halt = halt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) halt_q <= 1'b0;
    else halt_q <= halt_d;
`else
  assign halt = 1'b0;
`endif
  always_comb begin
    q_data_d = q_data_q;
    q_pc_d = q_pc_q;
    q_err_d = q_err_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
    fetch_pc_d = accept ? fetch_pc_q + W'(4) : fetch_pc_q;
    resp_pc_d = push ? resp_pc_q + W'(4) : resp_pc_q;
    disc_cnt_d = (resp_rdy & drop) ? disc_cnt_q - CW'(1) : disc_cnt_q;
    outst_cnt_d = outst_cnt_q + CW'(accept) - CW'(resp_rdy);
    if (push) begin
      q_data_d[wr_ptr_q] = imem_rdata;
      q_pc_d[wr_ptr_q] = resp_pc_q;
      q_err_d[wr_ptr_q] = resp_er;
    end
    // everything still outstanding, minus a response landing now, is stale
    if (new_pc_req) begin
      fetch_pc_d = new_pc_al;
      resp_pc_d = new_pc_al;
      q_cnt_d = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      disc_cnt_d = outst_cnt_q - CW'(resp_rdy);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc_q <= RST_PC;
      resp_pc_q <= RST_PC;
      q_cnt_q <= '0;
      outst_cnt_q <= '0;
      disc_cnt_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      q_data_q <= '{default: '0};
      q_pc_q <= '{default: '0};
      q_err_q <= '{default: 1'b0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q <= resp_pc_d;
      q_cnt_q <= q_cnt_d;
      outst_cnt_q <= outst_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      q_data_q <= q_data_d;
      q_pc_q <= q_pc_d;
      q_err_q <= q_err_d;
    end
endmodule
